// File: rtl/dmem_pkg.sv
// ---------------------------------------------------------------------------
// dmem_pkg
// Shared types and helpers for the RV32I data memory / load-store formatter.
//   mem_funct3_e     : encodings of the load/store Funct3 field
//   XLEN             : data path width
//   is_legal_funct3  : 1 for any Funct3 that names a defined load or store
// ---------------------------------------------------------------------------
package dmem_pkg;

    localparam int XLEN = 32;

    typedef enum logic [2:0] {
        MEM_B  = 3'b000,
        MEM_H  = 3'b001,
        MEM_W  = 3'b010,
        MEM_BU = 3'b100,
        MEM_HU = 3'b101
    } mem_funct3_e;

    function automatic logic is_legal_funct3(input logic [2:0] f3);
        logic legal;
        case (f3)
            MEM_B, MEM_H, MEM_W, MEM_BU, MEM_HU: legal = 1'b1;
            default:                             legal = 1'b0;
        endcase
        return legal;
    endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// ---------------------------------------------------------------------------
// dmem_lane_align
// Purely combinational byte-lane steering for the data memory.
//   funct3   in   access type (byte / half / word, signed or unsigned)
//   a_lo     in   A[1:0], byte lane within the addressed word
//   raw_word in   word currently stored at the addressed index
//   wd       in   right-aligned store data
//   be       out  byte enables for a store (0 for undefined access types)
//   st_word  out  store data replicated onto the lanes it may land in
//   ld_value out  selected lane(s), sign/zero extended to XLEN
//   misalign out  halfword on an odd address or word on a non-zero lane
// ---------------------------------------------------------------------------
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic [2:0]      funct3,
    input  logic [1:0]      a_lo,
    input  logic [XLEN-1:0] raw_word,
    input  logic [XLEN-1:0] wd,
    output logic [3:0]      be,
    output logic [XLEN-1:0] st_word,
    output logic [XLEN-1:0] ld_value,
    output logic            misalign
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Little-endian: lane n holds bits [8n+7:8n]; halfwords live in lane pairs.
    assign byte_sel = raw_word[{a_lo, 3'b000} +: 8];
    assign half_sel = raw_word[{a_lo[1], 4'b0000} +: 16];

    always_comb begin
        be       = 4'b0000;
        st_word  = '0;
        ld_value = '0;
        misalign = 1'b0;
        case (funct3)
            MEM_B, MEM_BU: begin
                be       = 4'b0001 << a_lo;
                st_word  = {4{wd[7:0]}};
                // funct3[2] distinguishes the unsigned variant.
                ld_value = funct3[2] ? {24'b0, byte_sel}
                                     : {{24{byte_sel[7]}}, byte_sel};
            end
            MEM_H, MEM_HU: begin
                misalign = a_lo[0];
                be       = a_lo[1] ? 4'b1100 : 4'b0011;
                st_word  = {2{wd[15:0]}};
                ld_value = funct3[2] ? {16'b0, half_sel}
                                     : {{16{half_sel[15]}}, half_sel};
            end
            MEM_W: begin
                misalign = (a_lo != 2'b00);
                be       = 4'b1111;
                st_word  = wd;
                ld_value = raw_word;
            end
            default: begin
                // Undefined encodings: no lanes touched; the top flags the fault.
                be = 4'b0000;
            end
        endcase
    end

endmodule

// File: rtl/data_memory_lsu.sv
// ---------------------------------------------------------------------------
// data_memory_lsu
// Word-organised RV32I data memory with byte-lane writes, sign/zero extended
// loads, fault detection with sticky capture, and selectable read latency.
//   clk          in   rising-edge clock
//   n_rst        in   asynchronous active-low reset (clears memory too)
//   we / re      in   store / load enable
//   funct3       in   access type (see dmem_pkg::mem_funct3_e)
//   a            in   byte address
//   wd           in   right-aligned store data
//   rd           out  extended load data (0 when not a valid load)
//   rd_valid     out  rd holds valid load data
//   misaligned   out  combinational fault flag for the current access
//   fault_sticky out  set by any faulting access until cleared
//   fault_addr   out  address of the first fault since the last clear
//   clr_fault    in   synchronous clear of fault_sticky / fault_addr
// ---------------------------------------------------------------------------
module data_memory_lsu
    import dmem_pkg::*;
#(
    parameter int ADDR_WIDTH   = 32,
    parameter int DEPTH_WORDS  = 256,
    parameter int READ_LATENCY = 0
) (
    input  logic                  clk,
    input  logic                  n_rst,
    input  logic                  we,
    input  logic                  re,
    input  logic [2:0]            funct3,
    input  logic [ADDR_WIDTH-1:0] a,
    input  logic [XLEN-1:0]       wd,
    output logic [XLEN-1:0]       rd,
    output logic                  rd_valid,
    output logic                  misaligned,
    output logic                  fault_sticky,
    output logic [ADDR_WIDTH-1:0] fault_addr,
    input  logic                  clr_fault
);

    localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    // Fits in ADDR_WIDTH bits because 4*DEPTH_WORDS <= 2**ADDR_WIDTH.
    localparam logic [ADDR_WIDTH-1:0] DEPTH_LIMIT = ADDR_WIDTH'(DEPTH_WORDS);

    // Refuse to elaborate a memory larger than the byte address space.
    if ((64'(DEPTH_WORDS) * 64'd4) > (64'd1 << ADDR_WIDTH)) begin : g_depth_check
        $error("data_memory_lsu: 4*DEPTH_WORDS exceeds 2**ADDR_WIDTH");
    end

    if (READ_LATENCY != 0 && READ_LATENCY != 1) begin : g_latency_check
        $error("data_memory_lsu: READ_LATENCY must be 0 or 1");
    end

    logic [IDX_W-1:0] word_idx;
    logic             in_range;
    logic             unsigned_store;
    logic             illegal_f3;
    logic             fault;
    logic             access;
    logic             store_ok;
    logic             load_ok;
    logic [3:0]       be;
    logic [XLEN-1:0]  st_word;
    logic [XLEN-1:0]  raw_word;
    logic [XLEN-1:0]  lane_word;
    logic [XLEN-1:0]  ld_value;
    logic             lane_misalign;
    logic [XLEN-1:0]  load_data;

    assign word_idx = a[IDX_W+1:2];
    assign in_range = ({2'b00, a[ADDR_WIDTH-1:2]} < DEPTH_LIMIT);

    // ------------------------------------------------------------------
    // Fault classification
    // ------------------------------------------------------------------
    assign unsigned_store = we && ((funct3 == MEM_BU) || (funct3 == MEM_HU));
    assign illegal_f3     = !is_legal_funct3(funct3);
    assign fault          = lane_misalign | ~in_range | illegal_f3 | unsigned_store;
    assign access         = we | re;
    assign misaligned     = fault & access;
    assign store_ok       = we & ~fault;
    assign load_ok        = re & ~fault;

    dmem_lane_align u_align (
        .funct3   (funct3),
        .a_lo     (a[1:0]),
        .raw_word (raw_word),
        .wd       (wd),
        .be       (be),
        .st_word  (st_word),
        .ld_value (ld_value),
        .misalign (lane_misalign)
    );

    // ------------------------------------------------------------------
    // Storage: one byte-wide array per lane so each lane has its own
    // write enable. Reads see pre-edge contents, which gives read-first
    // behaviour for a simultaneous store and load.
    // ------------------------------------------------------------------
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        logic [7:0] lane_mem [DEPTH_WORDS];

        always_ff @(posedge clk or negedge n_rst) begin
            if (!n_rst) begin
                for (int i = 0; i < DEPTH_WORDS; i++) begin
                    lane_mem[i] <= '0;
                end
            end else if (store_ok && be[gi]) begin
                lane_mem[word_idx] <= st_word[8*gi +: 8];
            end
        end

        assign lane_word[8*gi +: 8] = lane_mem[word_idx];
    end

    // Out-of-range indices may alias unimplemented entries; never expose them.
    assign raw_word  = in_range ? lane_word : '0;
    assign load_data = load_ok ? ld_value : '0;

    // ------------------------------------------------------------------
    // Read latency
    // ------------------------------------------------------------------
    if (READ_LATENCY == 1) begin : g_rd_reg
        logic [XLEN-1:0] rd_reg;
        logic            rd_valid_reg;

        always_ff @(posedge clk or negedge n_rst) begin
            if (!n_rst) begin
                rd_reg       <= '0;
                rd_valid_reg <= 1'b0;
            end else begin
                rd_reg       <= load_data;
                rd_valid_reg <= load_ok;
            end
        end

        assign rd       = rd_reg;
        assign rd_valid = rd_valid_reg;
    end else begin : g_rd_comb
        // Reset forces the combinational read path quiet as well.
        assign rd       = n_rst ? load_data : '0;
        assign rd_valid = n_rst & load_ok;
    end

    // ------------------------------------------------------------------
    // Fault tracking: first fault wins; a fault in the same cycle as a
    // clear re-arms the capture with the new address.
    // ------------------------------------------------------------------
    logic                  fault_sticky_reg, fault_sticky_next;
    logic [ADDR_WIDTH-1:0] fault_addr_reg,   fault_addr_next;

    always_comb begin
        fault_sticky_next = fault_sticky_reg;
        fault_addr_next   = fault_addr_reg;
        if (misaligned && (clr_fault || !fault_sticky_reg)) begin
            fault_sticky_next = 1'b1;
            fault_addr_next   = a;
        end else if (clr_fault) begin
            fault_sticky_next = 1'b0;
            fault_addr_next   = '0;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            fault_sticky_reg <= 1'b0;
            fault_addr_reg   <= '0;
        end else begin
            fault_sticky_reg <= fault_sticky_next;
            fault_addr_reg   <= fault_addr_next;
        end
    end

    assign fault_sticky = fault_sticky_reg;
    assign fault_addr   = fault_addr_reg;

endmodule

// File: tb/tb_data_memory_lsu.sv
// ---------------------------------------------------------------------------
// tb_data_memory_lsu
// Directed bench driving two instances (READ_LATENCY 0 and 1) with the same
// inputs. Inputs change on the falling edge; combinational results are
// sampled 1 ns later and registered results on the next falling edge.
// ---------------------------------------------------------------------------
module tb_data_memory_lsu;

    logic        clk = 1'b0;
    logic        n_rst;
    logic        we, re, clr_fault;
    logic [2:0]  funct3;
    logic [31:0] a, wd;

    logic [31:0] rd0, rd1, fault_addr0, fault_addr1;
    logic        rd_valid0, rd_valid1, mis0, mis1, sticky0, sticky1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    data_memory_lsu #(.ADDR_WIDTH(32), .DEPTH_WORDS(256), .READ_LATENCY(0)) u_dut0 (
        .clk(clk), .n_rst(n_rst), .we(we), .re(re), .funct3(funct3), .a(a), .wd(wd),
        .rd(rd0), .rd_valid(rd_valid0), .misaligned(mis0),
        .fault_sticky(sticky0), .fault_addr(fault_addr0), .clr_fault(clr_fault)
    );

    data_memory_lsu #(.ADDR_WIDTH(32), .DEPTH_WORDS(256), .READ_LATENCY(1)) u_dut1 (
        .clk(clk), .n_rst(n_rst), .we(we), .re(re), .funct3(funct3), .a(a), .wd(wd),
        .rd(rd1), .rd_valid(rd_valid1), .misaligned(mis1),
        .fault_sticky(sticky1), .fault_addr(fault_addr1), .clr_fault(clr_fault)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
        $display("check %-14s observed=%h expected=%h", tag, obs, expv);
    endtask

    task automatic apply(input logic w, input logic r, input logic [2:0] f,
                         input logic [31:0] addr, input logic [31:0] d, input logic c);
        we = w; re = r; funct3 = f; a = addr; wd = d; clr_fault = c;
    endtask

    initial begin
        n_rst = 1'b0;
        apply(0, 0, 3'b010, 32'h0, 32'h0, 0);
        #1;
        chk("rst_rd0",     rd0, 32'h0);
        chk("rst_rd1",     rd1, 32'h0);
        chk("rst_valid1",  {31'b0, rd_valid1}, 32'h0);
        chk("rst_sticky",  {31'b0, sticky1}, 32'h0);
        chk("rst_faddr",   fault_addr1, 32'h0);
        @(negedge clk); @(negedge clk);
        n_rst = 1'b1;

        // LW 0x40 after reset
        apply(0, 1, 3'b010, 32'h40, 32'h0, 0); #1;
        chk("lw40_rd0",    rd0, 32'h0);
        chk("lw40_v0",     {31'b0, rd_valid0}, 32'h1);
        @(negedge clk);
        chk("lw40_rd1",    rd1, 32'h0);
        chk("lw40_v1",     {31'b0, rd_valid1}, 32'h1);
        chk("lw40_sticky", {31'b0, sticky0}, 32'h0);

        // SW 0x10 DEADBEEF then sub-word loads
        apply(1, 0, 3'b010, 32'h10, 32'hDEADBEEF, 0); #1;
        chk("sw10_mis",    {31'b0, mis0}, 32'h0);
        chk("sw10_v0",     {31'b0, rd_valid0}, 32'h0);
        @(negedge clk);
        chk("sw10_v1",     {31'b0, rd_valid1}, 32'h0);
        apply(0, 1, 3'b000, 32'h13, 32'h0, 0); #1;
        chk("lb13_rd0",    rd0, 32'hFFFFFFDE);
        @(negedge clk);
        chk("lb13_rd1",    rd1, 32'hFFFFFFDE);
        apply(0, 1, 3'b100, 32'h13, 32'h0, 0); #1;
        chk("lbu13_rd0",   rd0, 32'h000000DE);
        @(negedge clk);
        chk("lbu13_rd1",   rd1, 32'h000000DE);
        apply(0, 1, 3'b001, 32'h10, 32'h0, 0); #1;
        chk("lh10_rd0",    rd0, 32'hFFFFBEEF);
        @(negedge clk);
        chk("lh10_rd1",    rd1, 32'hFFFFBEEF);
        apply(0, 1, 3'b101, 32'h12, 32'h0, 0); #1;
        chk("lhu12_rd0",   rd0, 32'h0000DEAD);
        @(negedge clk);
        chk("lhu12_rd1",   rd1, 32'h0000DEAD);

        // Byte / half stores into a cleared word
        apply(1, 0, 3'b010, 32'h20, 32'h0, 0);        @(negedge clk);
        apply(1, 0, 3'b000, 32'h21, 32'h000000AB, 0); @(negedge clk);
        apply(1, 0, 3'b001, 32'h22, 32'h00001234, 0); @(negedge clk);
        apply(0, 1, 3'b010, 32'h20, 32'h0, 0); #1;
        chk("lw20_rd0",    rd0, 32'h1234AB00);
        @(negedge clk);
        chk("lw20_rd1",    rd1, 32'h1234AB00);

        // Last legal word, upper boundary
        apply(1, 0, 3'b010, 32'h3FC, 32'hA5A55A5A, 0); #1;
        chk("sw3fc_mis",   {31'b0, mis0}, 32'h0);
        @(negedge clk);
        apply(0, 1, 3'b010, 32'h3FC, 32'h0, 0); #1;
        chk("lw3fc_rd0",   rd0, 32'hA5A55A5A);
        @(negedge clk);

        // Faulting store leaves memory untouched; first fault address sticks
        apply(1, 0, 3'b010, 32'h30, 32'h76543210, 0); @(negedge clk);
        apply(1, 0, 3'b010, 32'h32, 32'h11111111, 0); #1;
        chk("sw32_mis",    {31'b0, mis0}, 32'h1);
        @(negedge clk);
        chk("sw32_sticky", {31'b0, sticky0}, 32'h1);
        chk("sw32_faddr",  fault_addr0, 32'h32);
        apply(0, 1, 3'b010, 32'h30, 32'h0, 0); #1;
        chk("lw30_rd0",    rd0, 32'h76543210);
        @(negedge clk);
        apply(0, 1, 3'b001, 32'h401, 32'h0, 0); #1;
        chk("lh401_mis",   {31'b0, mis0}, 32'h1);
        chk("lh401_v0",    {31'b0, rd_valid0}, 32'h0);
        chk("lh401_rd0",   rd0, 32'h0);
        @(negedge clk);
        chk("lh401_faddr", fault_addr1, 32'h32);
        chk("lh401_v1",    {31'b0, rd_valid1}, 32'h0);
        apply(0, 0, 3'b010, 32'h0, 32'h0, 1); @(negedge clk);
        chk("clr_sticky",  {31'b0, sticky0}, 32'h0);
        chk("clr_faddr",   fault_addr0, 32'h0);

        // Other fault classes; clear coinciding with a new fault
        apply(1, 0, 3'b100, 32'h0, 32'h0, 0); #1;
        chk("sbu_mis",     {31'b0, mis0}, 32'h1);
        apply(0, 1, 3'b011, 32'h0, 32'h0, 0); #1;
        chk("f3_011_mis",  {31'b0, mis0}, 32'h1);
        apply(0, 0, 3'b011, 32'h0, 32'h0, 0); #1;
        chk("noacc_mis",   {31'b0, mis0}, 32'h0);
        apply(0, 1, 3'b010, 32'h400, 32'h0, 0); #1;
        chk("lw400_mis",   {31'b0, mis0}, 32'h1);
        @(negedge clk);
        chk("lw400_faddr", fault_addr0, 32'h400);
        apply(0, 1, 3'b010, 32'h5, 32'h0, 1); @(negedge clk);
        chk("clrnew_stk",  {31'b0, sticky1}, 32'h1);
        chk("clrnew_faddr", fault_addr1, 32'h5);
        apply(0, 0, 3'b010, 32'h0, 32'h0, 1); @(negedge clk);
        chk("clr2_sticky", {31'b0, sticky1}, 32'h0);

        // Read-during-write returns old data; valid is a single-cycle pulse
        apply(1, 0, 3'b010, 32'h8, 32'h5, 0); @(negedge clk);
        apply(1, 1, 3'b010, 32'h8, 32'h9, 0); #1;
        chk("rdw_rd0",     rd0, 32'h5);
        @(negedge clk);
        chk("rdw_rd1",     rd1, 32'h5);
        chk("rdw_v1",      {31'b0, rd_valid1}, 32'h1);
        apply(0, 0, 3'b010, 32'h8, 32'h0, 0); @(negedge clk);
        chk("pulse_v1",    {31'b0, rd_valid1}, 32'h0);
        chk("pulse_rd1",   rd1, 32'h0);
        apply(0, 1, 3'b010, 32'h8, 32'h0, 0); #1;
        chk("lw8_rd0",     rd0, 32'h9);
        @(negedge clk);
        chk("lw8_rd1",     rd1, 32'h9);

        // Asynchronous reset in mid-cycle
        apply(1, 0, 3'b010, 32'h4, 32'hCAFE0001, 0); @(negedge clk);
        apply(0, 1, 3'b010, 32'h4, 32'h0, 0); #1;
        chk("lw4_rd0",     rd0, 32'hCAFE0001);
        @(negedge clk);
        chk("lw4_rd1",     rd1, 32'hCAFE0001);
        #2 n_rst = 1'b0;
        #1;
        chk("arst_rd0",    rd0, 32'h0);
        chk("arst_v0",     {31'b0, rd_valid0}, 32'h0);
        chk("arst_rd1",    rd1, 32'h0);
        chk("arst_v1",     {31'b0, rd_valid1}, 32'h0);
        @(negedge clk);
        n_rst = 1'b1;
        #1;
        chk("post_rd0",    rd0, 32'h0);
        chk("post_v0",     {31'b0, rd_valid0}, 32'h1);
        @(negedge clk);
        chk("post_rd1",    rd1, 32'h0);
        chk("post_v1",     {31'b0, rd_valid1}, 32'h1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/data_memory_lsu.md
Name: data_memory_lsu

Overview:
Parametrised RV32I data memory with an integrated load/store formatter. It is the successor to the fixed 8-bit data memory.
- Word-organised storage with byte-lane writes.
- Byte, halfword and word loads, with sign or zero extension selected by funct3.
- Misalignment and out-of-range detection.
- Selectable combinational or registered read latency.
It sits between the ALU result/rs2 path and the writeback mux of the single-cycle core; READ_LATENCY=1 is reserved for the future pipelined core.

Parameters:
ADDR_WIDTH, 32, byte-address width of A.
DEPTH_WORDS, 256, number of 32-bit words stored; legal byte addresses are 0 .. 4*DEPTH_WORDS-1.
READ_LATENCY, 0, 0 = combinational read; 1 = read registered on rising Clk edge.

Ports:
Clk  in  1  clock, rising edge active.
n_Rst  in  1  asynchronous reset, active-low.
WE  in  1  store enable.
RE  in  1  load enable.
Funct3  in  3  access type: 000 LB/SB, 001 LH/SH, 010 LW/SW, 100 LBU, 101 LHU.
A  in  ADDR_WIDTH  byte address.
WD  in  32  store data, right-aligned (SB uses WD[7:0], SH uses WD[15:0]).
RD  out  32  load data, extended to 32 bits.
RD_Valid  out  1  RD holds valid load data.
Misaligned  out  1  combinational fault flag for the current access.
Fault_Sticky  out  1  set by any faulting access; held until cleared.
Fault_Addr  out  ADDR_WIDTH  address of the first fault since the last clear.
Clr_Fault  in  1  synchronous clear of Fault_Sticky and Fault_Addr.

Behaviour:
- Reset (n_Rst=0, asynchronous):
  - all DEPTH_WORDS entries cleared to 0;
  - RD=0, RD_Valid=0, Fault_Sticky=0, Fault_Addr=0;
  - writes are blocked while reset is asserted;
  - reset in mid-operation discards any pending registered read.
- Addressing:
  - word index = A >> 2; lane = A[1:0]; memory is little-endian.
- Fault condition for an access (WE or RE high) is any of:
  - halfword access with A[0]=1;
  - word access with A[1:0]!=0;
  - word index >= DEPTH_WORDS;
  - Funct3 in {011,110,111};
  - WE=1 with Funct3 in {100,101} (no unsigned store exists).
  - Misaligned = fault & (WE|RE), combinational.
- Stores, on the rising edge with WE=1 and no fault:
  - SB writes lane A[1:0];
  - SH writes lanes {A[1],0} and {A[1],1};
  - SW writes all four lanes;
  - other lanes are unchanged;
  - a faulting store leaves memory unmodified.
- Loads:
  - the lane(s) selected as for stores are extracted;
  - LB/LH sign-extend, LBU/LHU zero-extend, LW passes the word through.
  - Faulting load or RE=0: RD=0, RD_Valid=0.
- READ_LATENCY=0:
  - RD and RD_Valid follow A, Funct3 and RE combinationally;
  - a store becomes visible to a load one cycle after its edge, i.e. same-cycle read-during-write returns old data.
- READ_LATENCY=1:
  - RD and RD_Valid are registered at the edge where RE is sampled;
  - RD_Valid is a 1-cycle pulse per load;
  - read-first: simultaneous WE and RE to the same word returns pre-write data.
- WE and RE both high: the store is performed and the load returns old data, for either latency.
- Fault tracking, on the rising edge:
  - if fault & (WE|RE) and Fault_Sticky=0: set Fault_Sticky and capture A into Fault_Addr;
  - later faults do not overwrite Fault_Addr;
  - Clr_Fault clears both registers;
  - Clr_Fault together with a new fault in the same cycle: the new fault wins (set and capture).
- Elaboration: DEPTH_WORDS must satisfy 4*DEPTH_WORDS <= 2**ADDR_WIDTH; elaboration fails otherwise.

Decomposition:
- Package dmem_pkg:
  - enum mem_funct3_e (MEM_B, MEM_H, MEM_W, MEM_BU, MEM_HU);
  - localparam XLEN=32;
  - function is_legal_funct3.
- Sub-module dmem_lane_align (combinational):
  - inputs Funct3, A[1:0], raw word, WD;
  - outputs 4-bit byte-enable, lane-positioned store word, extended load value, misalign bit.
- The top holds the array, the latency register, fault registers and range check.

Test Plan:
- Reset then LW A=0x40 → RD=0x00000000; Fault_Sticky=0.
- SW A=0x10 WD=0xDEADBEEF; LB A=0x13 → 0xFFFFFFDE; LBU A=0x13 → 0x000000DE; LH A=0x10 → 0xFFFFBEEF; LHU A=0x12 → 0x0000DEAD.
- SW A=0x20 WD=0; SB A=0x21 WD=0x000000AB; SH A=0x22 WD=0x00001234; LW A=0x20 → 0x1234AB00.
- SW A=0x32 WD=0x11111111 → Misaligned=1, Fault_Sticky=1, Fault_Addr=0x32, LW A=0x30 still returns prior value. Then LH A=0x401 → Fault_Addr stays 0x32. Clr_Fault → both cleared.
- READ_LATENCY=1, SW A=0x8 WD=0x5 then same-cycle WE(WD=0x9)+RE A=0x8 → next-cycle RD=0x5, RD_Valid pulse of 1 cycle; a following LW → 0x9.
- SW A=0x4 WD=0xCAFE0001, assert n_Rst=0 asynchronously mid-cycle → RD=0 and RD_Valid=0 immediately; after release LW A=0x4 → 0x00000000.
